// File: rtl/pmp_csr_file.sv
// PMP CSR writer: pmpcfg0/1 and pmpaddr0-7 with WARL/lock rules and registered NAPOT masks.
// Optional build macro PMP_LOCK_OVERRIDE_EN adds io_debug_mode, which bypasses every lock check.
module pmp_csr_file (
  input  logic        clock,
  input  logic        reset,
`ifdef PMP_LOCK_OVERRIDE_EN
  input  logic        io_debug_mode,
`endif
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_req_write,
  input  logic [11:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_rdata,
  output logic        io_resp_illegal,
  output logic        io_busy,
  output logic io_pmp_0_cfg_l, output logic [1:0] io_pmp_0_cfg_a, output logic io_pmp_0_cfg_x,
  output logic io_pmp_0_cfg_w, output logic io_pmp_0_cfg_r, output logic [29:0] io_pmp_0_addr, output logic [31:0] io_pmp_0_mask,
  output logic io_pmp_1_cfg_l, output logic [1:0] io_pmp_1_cfg_a, output logic io_pmp_1_cfg_x,
  output logic io_pmp_1_cfg_w, output logic io_pmp_1_cfg_r, output logic [29:0] io_pmp_1_addr, output logic [31:0] io_pmp_1_mask,
  output logic io_pmp_2_cfg_l, output logic [1:0] io_pmp_2_cfg_a, output logic io_pmp_2_cfg_x,
  output logic io_pmp_2_cfg_w, output logic io_pmp_2_cfg_r, output logic [29:0] io_pmp_2_addr, output logic [31:0] io_pmp_2_mask,
  output logic io_pmp_3_cfg_l, output logic [1:0] io_pmp_3_cfg_a, output logic io_pmp_3_cfg_x,
  output logic io_pmp_3_cfg_w, output logic io_pmp_3_cfg_r, output logic [29:0] io_pmp_3_addr, output logic [31:0] io_pmp_3_mask,
  output logic io_pmp_4_cfg_l, output logic [1:0] io_pmp_4_cfg_a, output logic io_pmp_4_cfg_x,
  output logic io_pmp_4_cfg_w, output logic io_pmp_4_cfg_r, output logic [29:0] io_pmp_4_addr, output logic [31:0] io_pmp_4_mask,
  output logic io_pmp_5_cfg_l, output logic [1:0] io_pmp_5_cfg_a, output logic io_pmp_5_cfg_x,
  output logic io_pmp_5_cfg_w, output logic io_pmp_5_cfg_r, output logic [29:0] io_pmp_5_addr, output logic [31:0] io_pmp_5_mask,
  output logic io_pmp_6_cfg_l, output logic [1:0] io_pmp_6_cfg_a, output logic io_pmp_6_cfg_x,
  output logic io_pmp_6_cfg_w, output logic io_pmp_6_cfg_r, output logic [29:0] io_pmp_6_addr, output logic [31:0] io_pmp_6_mask,
  output logic io_pmp_7_cfg_l, output logic [1:0] io_pmp_7_cfg_a, output logic io_pmp_7_cfg_x,
  output logic io_pmp_7_cfg_w, output logic io_pmp_7_cfg_r, output logic [29:0] io_pmp_7_addr, output logic [31:0] io_pmp_7_mask
);

  // Handshake: a request is taken on any cycle with io_req_valid & io_req_ready; io_req_ready
  // is low only during the single mask-recompute cycle, and the response pulses one cycle later.

  logic [7:0]  cfg_q  [8];
  logic [7:0]  cfg_d  [8];
  logic [29:0] addr_q [8];
  logic [29:0] addr_d [8];
  logic [31:0] mask_q [8];
  logic        busy_q, resp_valid_q, resp_illegal_q;
  logic [31:0] resp_rdata_q, rdata_d;
  logic        accept, is_cfg, is_addr, legal, applied, cfg_sel, lock_bypass;
  logic [2:0]  idx;
  logic [7:0]  tor_lock;
  logic        unused_wdata;

`ifdef PMP_LOCK_OVERRIDE_EN
  assign lock_bypass = io_debug_mode;
`else
  assign lock_bypass = 1'b0;
`endif

  // Address bit 29 cannot reach mask bits [31:0] (its only effect is on t[30]), so it is not an input.
  function automatic logic [31:0] napot_mask(input logic [28:0] a, input logic a0);
    logic [29:0] base;
    logic [29:0] t;
    base = {a, a0};
    t    = base & ~(base + 30'd1);
    return {t, 2'b11};
  endfunction

  assign unused_wdata = ^{io_req_wdata[30:29], io_req_wdata[22:21], io_req_wdata[14:13], io_req_wdata[6:5]};

  assign accept  = io_req_valid & ~busy_q;
  assign is_cfg  = (io_req_addr[11:1] == 11'h1D0);
  assign is_addr = (io_req_addr[11:3] == 9'h076);
  assign legal   = is_cfg | is_addr;
  assign cfg_sel = io_req_addr[0];
  assign idx     = io_req_addr[2:0];

  always_comb begin
    tor_lock    = '0;
    for (int i = 0; i < 7; i++)
      tor_lock[i] = cfg_q[i+1][7] & (cfg_q[i+1][4:3] == 2'b01);
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    applied = 1'b0;
    rdata_d = '0;
    if (accept && io_req_write) begin
      if (is_cfg) begin
        for (int k = 0; k < 4; k++) begin
          if (!cfg_q[{cfg_sel, 2'(k)}][7] || lock_bypass) begin
            cfg_d[{cfg_sel, 2'(k)}] = {io_req_wdata[8*k+7], 2'b00, io_req_wdata[8*k+3 +: 2],
                                       io_req_wdata[8*k+2], io_req_wdata[8*k+1] & io_req_wdata[8*k],
                                       io_req_wdata[8*k]};
            applied = 1'b1;
          end
        end
      end else if (is_addr) begin
        if (!(cfg_q[idx][7] || tor_lock[idx]) || lock_bypass) begin
          addr_d[idx] = io_req_wdata[29:0];
          applied     = 1'b1;
        end
      end
    end else if (accept) begin
      if (is_cfg) begin
        for (int k = 0; k < 4; k++)
          rdata_d[8*k +: 8] = cfg_q[{cfg_sel, 2'(k)}];
      end else if (is_addr) begin
        rdata_d = {2'b00, addr_q[idx]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
        mask_q[i] <= '0;
      end
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_rdata_q   <= '0;
    end else begin
      cfg_q          <= cfg_d;
      addr_q         <= addr_d;
      busy_q         <= applied;
      resp_valid_q   <= accept;
      resp_illegal_q <= accept & ~legal;
      resp_rdata_q   <= rdata_d;
      // Masks follow the registers committed on the previous edge.
      if (busy_q) begin
        for (int i = 0; i < 8; i++)
          mask_q[i] <= napot_mask(addr_q[i][28:0], cfg_q[i][3]);
      end
    end
  end

  assign io_req_ready    = ~busy_q;
  assign io_busy         = busy_q;
  assign io_resp_valid   = resp_valid_q;
  assign io_resp_rdata   = resp_rdata_q;
  assign io_resp_illegal = resp_illegal_q;

  assign {io_pmp_0_cfg_l, io_pmp_0_cfg_a, io_pmp_0_cfg_x, io_pmp_0_cfg_w, io_pmp_0_cfg_r} = {cfg_q[0][7], cfg_q[0][4:0]};
  assign {io_pmp_1_cfg_l, io_pmp_1_cfg_a, io_pmp_1_cfg_x, io_pmp_1_cfg_w, io_pmp_1_cfg_r} = {cfg_q[1][7], cfg_q[1][4:0]};
  assign {io_pmp_2_cfg_l, io_pmp_2_cfg_a, io_pmp_2_cfg_x, io_pmp_2_cfg_w, io_pmp_2_cfg_r} = {cfg_q[2][7], cfg_q[2][4:0]};
  assign {io_pmp_3_cfg_l, io_pmp_3_cfg_a, io_pmp_3_cfg_x, io_pmp_3_cfg_w, io_pmp_3_cfg_r} = {cfg_q[3][7], cfg_q[3][4:0]};
  assign {io_pmp_4_cfg_l, io_pmp_4_cfg_a, io_pmp_4_cfg_x, io_pmp_4_cfg_w, io_pmp_4_cfg_r} = {cfg_q[4][7], cfg_q[4][4:0]};
  assign {io_pmp_5_cfg_l, io_pmp_5_cfg_a, io_pmp_5_cfg_x, io_pmp_5_cfg_w, io_pmp_5_cfg_r} = {cfg_q[5][7], cfg_q[5][4:0]};
  assign {io_pmp_6_cfg_l, io_pmp_6_cfg_a, io_pmp_6_cfg_x, io_pmp_6_cfg_w, io_pmp_6_cfg_r} = {cfg_q[6][7], cfg_q[6][4:0]};
  assign {io_pmp_7_cfg_l, io_pmp_7_cfg_a, io_pmp_7_cfg_x, io_pmp_7_cfg_w, io_pmp_7_cfg_r} = {cfg_q[7][7], cfg_q[7][4:0]};

  assign io_pmp_0_addr = addr_q[0];
  assign io_pmp_1_addr = addr_q[1];
  assign io_pmp_2_addr = addr_q[2];
  assign io_pmp_3_addr = addr_q[3];
  assign io_pmp_4_addr = addr_q[4];
  assign io_pmp_5_addr = addr_q[5];
  assign io_pmp_6_addr = addr_q[6];
  assign io_pmp_7_addr = addr_q[7];

  assign io_pmp_0_mask = mask_q[0];
  assign io_pmp_1_mask = mask_q[1];
  assign io_pmp_2_mask = mask_q[2];
  assign io_pmp_3_mask = mask_q[3];
  assign io_pmp_4_mask = mask_q[4];
  assign io_pmp_5_mask = mask_q[5];
  assign io_pmp_6_mask = mask_q[6];
  assign io_pmp_7_mask = mask_q[7];

endmodule
